// File: rtl/types.sv
// Shared ALU control encodings used between the decode stage and the ALU.
package types;
  typedef enum logic [6:0] {
    FUNCT7_DEFAULT = 7'b0000000,
    FUNCT7_NEG     = 7'b0100000
  } alu_funct7_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b111
  } alu_funct3_e;
endpackage

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: decodes the RV32 ALU subset, reads a 2R1W
// register file with writeback bypass, and holds one output entry.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              instr_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic                     wb_en_i,
  input  logic [4:0]               wb_addr_i,
  input  logic [XLEN-1:0]          wb_data_i,
  output logic [XLEN-1:0]          operand_1_o,
  output logic [XLEN-1:0]          operand_2_o,
  output types::alu_funct7_e       funct7_o,
  output types::alu_funct3_e       funct3_o,
  output logic [4:0]               rd_o,
  output logic                     illegal_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Handshake: instr_i transfers on a rising edge where instr_valid_i and
  // instr_ready_o are both high; the output entry transfers on an edge where
  // out_valid_o and out_ready_i are both high. A held entry stays bit-stable
  // until it transfers, and ready may accept a new entry on the same edge.
  logic accept;
  logic drain;

  logic [6:0] opcode;
  logic [4:0] rd_field;
  logic [2:0] funct3_field;
  logic [4:0] rs1_field;
  logic [4:0] rs2_field;
  logic [6:0] funct7_field;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_val;

  logic [XLEN-1:0]    dec_op1;
  logic [XLEN-1:0]    dec_op2;
  types::alu_funct7_e dec_f7;
  types::alu_funct3_e dec_f3;
  logic [4:0]         dec_rd;
  logic               dec_illegal;

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  logic               valid_q,   valid_d;
  logic [XLEN-1:0]    op1_q,     op1_d;
  logic [XLEN-1:0]    op2_q,     op2_d;
  types::alu_funct7_e f7_q,      f7_d;
  types::alu_funct3_e f3_q,      f3_d;
  logic [4:0]         rd_q,      rd_d;
  logic               illegal_q, illegal_d;

  assign instr_ready_o = !valid_q | out_ready_i;
  assign accept        = instr_valid_i & instr_ready_o;
  assign drain         = valid_q & out_ready_i;

  assign opcode       = instr_i[6:0];
  assign rd_field     = instr_i[11:7];
  assign funct3_field = instr_i[14:12];
  assign rs1_field    = instr_i[19:15];
  assign rs2_field    = instr_i[24:20];
  assign funct7_field = instr_i[31:25];
  assign imm_val      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};

  // Same-cycle writeback is forwarded so the operand matches program order.
  always_comb begin
    rs1_val = '0;
    if (rs1_field != 5'd0) begin
      if (wb_en_i && (wb_addr_i == rs1_field)) rs1_val = wb_data_i;
      else                                     rs1_val = regs_q[rs1_field];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_field != 5'd0) begin
      if (wb_en_i && (wb_addr_i == rs2_field)) rs2_val = wb_data_i;
      else                                     rs2_val = regs_q[rs2_field];
    end
  end

  always_comb begin
    dec_op1     = '0;
    dec_op2     = '0;
    dec_f7      = types::FUNCT7_DEFAULT;
    dec_f3      = types::ALU_ADD;
    dec_rd      = '0;
    dec_illegal = 1'b1;
    if (opcode == OPC_OP) begin
      if ((funct3_field == F3_ADD) &&
          ((funct7_field == F7_BASE) || (funct7_field == F7_ALT))) begin
        dec_illegal = 1'b0;
        dec_op2     = rs2_val;
        dec_f7      = (funct7_field == F7_ALT) ? types::FUNCT7_NEG : types::FUNCT7_DEFAULT;
      end else if ((funct3_field == F3_AND) && (funct7_field == F7_BASE)) begin
        dec_illegal = 1'b0;
        dec_op2     = rs2_val;
        dec_f3      = types::ALU_AND;
      end
    end else if (opcode == OPC_OP_IMM) begin
      if (funct3_field == F3_ADD) begin
        dec_illegal = 1'b0;
        dec_op2     = imm_val;
      end else if (funct3_field == F3_AND) begin
        dec_illegal = 1'b0;
        dec_op2     = imm_val;
        dec_f3      = types::ALU_AND;
      end
    end
    if (!dec_illegal) begin
      dec_op1 = rs1_val;
      dec_rd  = rd_field;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    f7_d      = f7_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    if (accept) begin
      valid_d   = 1'b1;
      op1_d     = dec_op1;
      op2_d     = dec_op2;
      f7_d      = dec_f7;
      f3_d      = dec_f3;
      rd_d      = dec_rd;
      illegal_d = dec_illegal;
    end else if (drain) begin
      valid_d   = 1'b0;
    end
  end

  // Writeback runs every cycle regardless of handshake state; x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wb_en_i && (wb_addr_i != 5'd0)) regs_d[wb_addr_i] = wb_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q    <= '{default: '0};
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      f7_q      <= types::FUNCT7_DEFAULT;
      f3_q      <= types::ALU_ADD;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      f7_q      <= f7_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid_o = valid_q;
  assign operand_1_o = op1_q;
  assign operand_2_o = op2_q;
  assign funct7_o    = f7_q;
  assign funct3_o    = f3_q;
  assign rd_o        = rd_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_decode_stage;

  localparam int EW = 80;  // {illegal, rd, f3, f7, op2, op1}

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic        wb_en_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [31:0] operand_1_o;
  logic [31:0] operand_2_o;
  types::alu_funct7_e funct7_o;
  types::alu_funct3_e funct3_o;
  logic [4:0]  rd_o;
  logic        illegal_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   ref_regs [32];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .operand_1_o(operand_1_o), .operand_2_o(operand_2_o),
    .funct7_o(funct7_o), .funct3_o(funct3_o), .rd_o(rd_o), .illegal_o(illegal_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return ref_regs[a];
  endfunction

  function automatic logic [EW-1:0] pack(input logic ill, input logic [4:0] rd,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] op2, input logic [31:0] op1);
    return {ill, rd, f3, f7, op2, op1};
  endfunction

  // Reference decode: what the ALU should see for this instruction word.
  function automatic logic [EW-1:0] model_decode(input logic [31:0] ins, input logic we,
                                                 input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] a, b, imm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = read_reg(ins[19:15], we, wa, wd);
    b   = read_reg(ins[24:20], we, wa, wd);
    imm = 32'(signed'(ins[31:20]));
    if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'd0)  return pack(1'b0, rd, 3'b000, 7'h00, b, a);
    if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h20) return pack(1'b0, rd, 3'b000, 7'h20, b, a);
    if (op == 7'b0110011 && f3 == 3'd7 && f7 == 7'd0)  return pack(1'b0, rd, 3'b111, 7'h00, b, a);
    if (op == 7'b0010011 && f3 == 3'd0)                return pack(1'b0, rd, 3'b000, 7'h00, imm, a);
    if (op == 7'b0010011 && f3 == 3'd7)                return pack(1'b0, rd, 3'b111, 7'h00, imm, a);
    return pack(1'b1, 5'd0, 3'b000, 7'h00, 32'd0, 32'd0);
  endfunction

  // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
  task automatic cycle(input logic [31:0] ins, input logic v, input logic ordy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rst, input string tag);
    logic exp_ready, acc, drn;
    logic [EW-1:0] act;
    @(negedge clk);
    rst_i = rst; instr_i = ins; instr_valid_i = v; out_ready_i = ordy;
    wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
    #1;
    exp_ready = (exp_q.size() == 0) || ordy;
    n_cmp++;
    if (instr_ready_o !== exp_ready) begin
      n_err++;
      $display("FAIL %s instr_ready got=%b exp=%b @%0t", tag, instr_ready_o, exp_ready, $time);
    end
    n_cmp++;
    if (out_valid_o !== (exp_q.size() != 0)) begin
      n_err++;
      $display("FAIL %s out_valid got=%b exp=%b @%0t", tag, out_valid_o, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0) begin
      act = {illegal_o, rd_o, funct3_o, funct7_o, operand_2_o, operand_1_o};
      n_cmp++;
      if (act !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s entry got=%h exp=%h @%0t", tag, act, exp_q[0], $time);
      end
    end
    acc = v && exp_ready;
    drn = (exp_q.size() != 0) && ordy;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model_decode(ins, we, wa, wd));
      if (we && wa != 5'd0) ref_regs[wa] = wd;
    end
  endtask

  task automatic idle(input logic ordy, input string tag);
    cycle(32'd0, 1'b0, ordy, 1'b0, 5'd0, 32'd0, 1'b0, tag);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    cycle(32'd0, 1'b0, 1'b1, 1'b1, a, d, 1'b0, "wb");
  endtask

  task automatic issue(input logic [31:0] ins, input logic ordy, input string tag);
    cycle(ins, 1'b1, ordy, 1'b0, 5'd0, 32'd0, 1'b0, tag);
  endtask

  task automatic expect_out(input string tag, input logic [EW-1:0] want);
    logic [EW-1:0] act;
    act = {illegal_o, rd_o, funct3_o, funct7_o, operand_2_o, operand_1_o};
    n_cmp++;
    if (out_valid_o !== 1'b1 || act !== want) begin
      n_err++;
      $display("FAIL %s const valid=%b got=%h exp=%h", tag, out_valid_o, act, want);
    end
  endtask

  task automatic expect_reset_values(input string tag);
    logic [EW:0] act;
    act = {out_valid_o, illegal_o, rd_o, funct3_o, funct7_o, operand_2_o, operand_1_o};
    n_cmp++;
    if (act !== '0 || instr_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s reset_state got=%h ready=%b exp=0 ready=1", tag, act, instr_ready_o);
    end
  endtask

  task automatic test_reset();
    cycle(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, "rst");
    cycle(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, "rst");
    idle(1'b0, "post_rst");
    expect_reset_values("test_reset");
  endtask

  task automatic test_add();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    issue(32'h002081B3, 1'b1, "add");
    idle(1'b0, "add_out");
    expect_out("add_const", pack(1'b0, 5'd3, 3'b000, 7'h00, 32'd3, 32'd5));
    idle(1'b1, "add_drain");
  endtask

  task automatic test_sub_addi();
    issue(32'h402081B3, 1'b1, "sub");
    idle(1'b0, "sub_out");
    expect_out("sub_const", pack(1'b0, 5'd3, 3'b000, 7'h20, 32'd3, 32'd5));
    issue(32'hFFF08213, 1'b1, "addi");
    idle(1'b0, "addi_out");
    expect_out("addi_const", pack(1'b0, 5'd4, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd5));
    idle(1'b1, "addi_drain");
  endtask

  task automatic test_bypass();
    cycle(i_type(12'h00F, 5'd1, 3'b111, 5'd5, 7'b0010011), 1'b1, 1'b1,
          1'b1, 5'd1, 32'd9, 1'b0, "andi_byp");
    idle(1'b0, "andi_out");
    expect_out("andi_const", pack(1'b0, 5'd5, 3'b111, 7'h00, 32'h0000_000F, 32'd9));
    // Writing x1 while the entry is held must not disturb it.
    cycle(32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd77, 1'b0, "held_wb");
    expect_out("held_const", pack(1'b0, 5'd5, 3'b111, 7'h00, 32'h0000_000F, 32'd9));
    idle(1'b1, "andi_drain");
  endtask

  task automatic test_stall();
    logic [31:0] nxt;
    nxt = r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd6, 7'b0110011);
    issue(32'h002081B3, 1'b0, "stall_load");
    for (int i = 0; i < 3; i++) issue(nxt, 1'b0, "stall_hold");
    issue(nxt, 1'b1, "stall_release");
    idle(1'b0, "stall_new");
    expect_out("stall_new_const", pack(1'b0, 5'd6, 3'b111, 7'h00, 32'd3, 32'd77));
    idle(1'b1, "stall_drain");
  endtask

  task automatic test_x0_illegal();
    wb(5'd0, 32'hDEAD);
    issue(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011), 1'b1, "x0_add");
    idle(1'b0, "x0_out");
    expect_out("x0_const", pack(1'b0, 5'd1, 3'b000, 7'h00, 32'd0, 32'd0));
    issue(32'h0020_8FFF, 1'b1, "illegal");
    idle(1'b0, "illegal_out");
    expect_out("illegal_const", pack(1'b1, 5'd0, 3'b000, 7'h00, 32'd0, 32'd0));
    issue(r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011), 1'b1, "illegal_f7");
    idle(1'b1, "illegal_drain");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 8; i++) wb(5'(i), 32'(i * 32'h1111));
    for (int i = 0; i < 6; i++)
      issue(r_type(7'h00, 5'(i + 1), 5'(i + 2), 3'b000, 5'(i + 8), 7'b0110011), 1'b1, "b2b");
    idle(1'b1, "b2b_drain");
  endtask

  task automatic test_reset_full();
    issue(32'h002081B3, 1'b0, "rfull_load");
    cycle(32'h002081B3, 1'b1, 1'b0, 1'b1, 5'd3, 32'h55, 1'b1, "rfull_rst");
    idle(1'b0, "rfull_after");
    expect_reset_values("reset_full");
    for (int i = 0; i < 32; i += 2)
      issue(r_type(7'h00, 5'(i + 1), 5'(i), 3'b000, 5'd1, 7'b0110011), 1'b1, "rfull_read");
    idle(1'b1, "rfull_drain");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0]  r1, r2, rd;
    for (int n = 0; n < 400; n++) begin
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 6))
        0: ins = r_type(7'h00, r2, r1, 3'b000, rd, 7'b0110011);
        1: ins = r_type(7'h20, r2, r1, 3'b000, rd, 7'b0110011);
        2: ins = r_type(7'h00, r2, r1, 3'b111, rd, 7'b0110011);
        3: ins = i_type(12'($urandom), r1, 3'b000, rd, 7'b0010011);
        4: ins = i_type(12'($urandom), r1, 3'b111, rd, 7'b0010011);
        5: ins = r_type(7'($urandom), r2, r1, 3'($urandom), rd, 7'b0110011);
        default: ins = $urandom;
      endcase
      cycle(ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 99) == 0), "random");
    end
    idle(1'b1, "random_drain");
    idle(1'b1, "random_end");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    test_reset();
    test_add();
    test_sub_addi();
    test_bypass();
    test_stall();
    test_x0_illegal();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
